mdu: RTL and testbench

MDU -- requirements
Module: mdu

---
 rtl/mdu.sv | 128 ++++++++++++
 tb/tb_mdu.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/mdu.sv
// mdu: iterative multiply/divide unit with HI/LO registers.
// Ports: clk/rst (async, active-high), start/op/a/b request in IDLE,
//        flush aborts the operation in flight, hi/lo result registers,
//        busy while an operation runs, done pulses when new hi/lo land.
module mdu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);
    localparam logic [1:0] IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2;
    localparam logic [2:0] OP_MULT = 3'd1, OP_MULTU = 3'd2, OP_DIV = 3'd3;
    localparam logic [2:0] OP_DIVU = 3'd4, OP_MTHI = 3'd5, OP_MTLO = 3'd6;

    logic [1:0]         state_q, state_d;
    logic [WIDTH-1:0]   cnt_q, cnt_d, acc_q, acc_d, md_q, md_d, opr_q, opr_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic               div_q, div_d, neg_q, neg_d, negr_q, negr_d, done_q, done_d;
    logic               sgn, arith, sa, sb;
    logic [WIDTH-1:0]   ua, ub;
    logic [WIDTH:0]     sum, shl, diff;
    logic [2*WIDTH-1:0] prod;

    assign sgn   = op == OP_MULT || op == OP_DIV;
    assign arith = op >= OP_MULT && op <= OP_DIVU;
    assign sa    = sgn & a[WIDTH-1];
    assign sb    = sgn & b[WIDTH-1];
    assign ua    = sa ? -a : a;
    assign ub    = sb ? -b : b;
    // Multiply: acc holds the running upper half, md shifts the multiplier out
    // and the product's low half in.
    assign sum   = {1'b0, acc_q} + {1'b0, md_q[0] ? opr_q : '0};
    // Divide: acc is the partial remainder, md shifts dividend out and quotient
    // in. The remainder stays below the divisor, so diff[WIDTH] is the borrow.
    assign shl   = {acc_q, md_q[WIDTH-1]};
    assign diff  = shl - {1'b0, opr_q};
    assign prod  = neg_q ? -{acc_q, md_q} : {acc_q, md_q};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        md_d    = md_q;
        opr_d   = opr_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        div_d   = div_q;
        neg_d   = neg_q;
        negr_d  = negr_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: if (start && !flush) begin
                if (arith) begin
                    acc_d   = '0;
                    md_d    = ua;
                    opr_d   = ub;
                    div_d   = op == OP_DIV || op == OP_DIVU;
                    // Divide by zero keeps the raw all-ones quotient unsigned.
                    neg_d   = (sa ^ sb) && (b != '0);
                    negr_d  = sa;
                    cnt_d   = '0;
                    state_d = CALC;
                end
                if (op == OP_MTHI) hi_d = a;
                if (op == OP_MTLO) lo_d = a;
            end
            CALC: if (flush) begin
                state_d = IDLE;
            end else begin
                acc_d   = div_q ? (diff[WIDTH] ? shl[WIDTH-1:0] : diff[WIDTH-1:0]) : sum[WIDTH:1];
                md_d    = div_q ? {md_q[WIDTH-2:0], ~diff[WIDTH]} : {sum[0], md_q[WIDTH-1:1]};
                cnt_d   = cnt_q + WIDTH'(1);
                if (cnt_q == WIDTH'(WIDTH - 1)) state_d = FIX;
            end
            FIX: begin
                state_d = IDLE;
                if (!flush) begin
                    hi_d   = div_q ? (negr_q ? -acc_q : acc_q) : prod[2*WIDTH-1:WIDTH];
                    lo_d   = div_q ? (neg_q ? -md_q : md_q) : prod[WIDTH-1:0];
                    done_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            md_q    <= '0;
            opr_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            div_q   <= 1'b0;
            neg_q   <= 1'b0;
            negr_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            md_q    <= md_d;
            opr_q   <= opr_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            div_q   <= div_d;
            neg_q   <= neg_d;
            negr_q  <= negr_d;
            done_q  <= done_d;
        end
    end

    assign hi   = hi_q;
    assign lo   = lo_q;
    assign busy = state_q != IDLE;
    assign done = done_q;
endmodule

// File: tb/tb_mdu.sv
// tb_mdu: directed and random checks of mdu against an arithmetic reference.
module tb_mdu;
    localparam int W = 32;

    logic         clk = 1'b0, rst = 1'b1, start = 1'b0, flush = 1'b0;
    logic [2:0]   op = 3'd0;
    logic [W-1:0] a = '0, b = '0;
    logic [W-1:0] hi, lo;
    logic         busy, done;
    logic [W-1:0] eh = '0, el = '0;
    int           checks = 0, passes = 0;

    mdu #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .flush(flush), .hi(hi), .lo(lo), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic void model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                                  inout logic [31:0] h, inout logic [31:0] l);
        case (o)
            3'd1: {h, l} = 64'(longint'($signed(x)) * longint'($signed(y)));
            3'd2: {h, l} = {32'b0, x} * {32'b0, y};
            3'd3: if (y == 0) begin
                l = '1; h = x;
            end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
                l = x; h = '0;
            end else begin
                l = 32'($signed(x) / $signed(y));
                h = 32'($signed(x) % $signed(y));
            end
            3'd4: if (y == 0) begin
                l = '1; h = x;
            end else begin
                l = x / y; h = x % y;
            end
            3'd5: h = x;
            3'd6: l = x;
            default: ;
        endcase
    endfunction

    task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        int n = 0;
        op = o; a = x; b = y; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = $urandom; b = $urandom; op = 3'($urandom);
        model(o, x, y, eh, el);
        while (busy && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk("busy_len", 64'(n), 64'(W + 1));
        chk("done_hi", done, 1);
        chk("hi", hi, eh);
        chk("lo", lo, el);
        @(negedge clk);
        chk("done_pulse", done, 0);
    endtask

    task automatic run_abort(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                             input int k, input bit use_rst);
        int dn = 0;
        op = o; a = x; b = y; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (k - 1) @(negedge clk);
        chk("abort_busy_before", busy, 1);
        if (use_rst) begin
            rst = 1'b1;
            #1;
            eh = '0; el = '0;
            chk("rst_hi", hi, 0);
            chk("rst_lo", lo, 0);
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            @(negedge clk);
            rst = 1'b0;
        end else begin
            flush = 1'b1;
            @(negedge clk);
            flush = 1'b0;
            chk("flush_busy", busy, 0);
            chk("flush_done", done, 0);
            chk("flush_hi", hi, eh);
            chk("flush_lo", lo, el);
        end
        repeat (W + 5) begin
            @(negedge clk);
            if (done) dn++;
        end
        chk("abort_no_done", 64'(dn), 0);
        chk("abort_idle", busy, 0);
        chk("abort_hi_kept", hi, eh);
        chk("abort_lo_kept", lo, el);
    endtask

    initial begin
        logic [2:0]  o;
        logic [31:0] x, y;
        int          n;
        @(negedge clk);
        @(negedge clk);
        chk("reset_hi", hi, 0);
        chk("reset_lo", lo, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        rst = 1'b0;
        run_op(3'd1, 32'hFFFF_FFFF, 32'h0000_0003);
        run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op(3'd3, 32'hFFFF_FFF9, 32'h0000_0002);
        run_op(3'd4, 32'h0000_0007, 32'h0000_0000);
        run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op(3'd3, 32'hFFFF_FFFB, 32'h0000_0000);
        run_op(3'd3, 32'h0000_0007, 32'hFFFF_FFFE);
        // MTHI / MTLO in IDLE
        op = 3'd5; a = 32'h1234_5678; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        model(3'd5, 32'h1234_5678, 0, eh, el);
        chk("mthi_hi", hi, eh);
        chk("mthi_lo", lo, el);
        chk("mthi_busy", busy, 0);
        chk("mthi_done", done, 0);
        op = 3'd6; a = 32'hCAFE_F00D; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        model(3'd6, 32'hCAFE_F00D, 0, eh, el);
        chk("mtlo_lo", lo, el);
        chk("mtlo_hi", hi, eh);
        chk("mtlo_done", done, 0);
        // MTHI while busy is ignored
        op = 3'd3; a = 32'd100; b = 32'd7; start = 1'b1;
        @(negedge clk);
        op = 3'd5; a = 32'hDEAD_BEEF;
        repeat (5) @(negedge clk);
        start = 1'b0;
        chk("busy_mthi_hi", hi, eh);
        model(3'd3, 32'd100, 32'd7, eh, el);
        n = 0;
        while (busy && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk("busy_mthi_done", done, 1);
        chk("busy_mthi_res_hi", hi, eh);
        chk("busy_mthi_res_lo", lo, el);
        @(negedge clk);
        chk("busy_mthi_after", hi, eh);
        // start with flush, and reserved ops, leave everything alone
        op = 3'd1; a = 32'd9; b = 32'd9; start = 1'b1; flush = 1'b1;
        @(negedge clk);
        chk("idle_flush_busy", busy, 0);
        op = 3'd5;
        @(negedge clk);
        chk("idle_flush_mthi", hi, eh);
        flush = 1'b0; op = 3'd7;
        @(negedge clk);
        chk("rsvd7_busy", busy, 0);
        op = 3'd0;
        @(negedge clk);
        start = 1'b0;
        chk("rsvd0_busy", busy, 0);
        chk("rsvd_hi", hi, eh);
        chk("rsvd_lo", lo, el);
        chk("rsvd_done", done, 0);
        // aborts: flush in CALC, flush in FIX, reset mid-operation
        run_abort(3'd3, 32'd1000, 32'd3, 10, 1'b0);
        run_abort(3'd1, 32'hFFFF_0000, 32'd5, W + 1, 1'b0);
        run_abort(3'd3, 32'd1000, 32'd3, 10, 1'b1);
        run_op(3'd2, 32'h0001_0001, 32'h0000_FFFF);
        for (int i = 0; i < 30; i++) begin
            o = 3'($urandom_range(1, 4));
            x = $urandom;
            y = ($urandom_range(0, 5) == 0) ? 32'd0 :
                ($urandom_range(0, 1) == 1) ? 32'($urandom) : 32'($urandom_range(1, 50));
            run_op(o, x, y);
        end
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
